// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared state encoding, beat counter width and index-width helper for the write arbiter.
package fifo_arb_pkg;
    typedef enum logic {IDLE, OWN} arb_state_t;
    localparam int BEAT_W = 8;
    function automatic int rr_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request/data bus and fifo write port seen by the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int F_WIDTH = 8
);
    localparam int IW = rr_idx_w(N_REQ);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*F_WIDTH-1:0] din_bus;
    logic [N_REQ-1:0]         gnt;
    logic                     fifo_full;
    logic                     fifo_enq;
    logic [F_WIDTH-1:0]       fifo_din;
    logic                     busy;
    logic [IW-1:0]            owner;
    modport master (output req, din_bus, fifo_full, input gnt, fifo_enq, fifo_din, busy, owner);
    modport slave  (input req, din_bus, fifo_full, output gnt, fifo_enq, fifo_din, busy, owner);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker; first set req at or after ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = rr_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx
);
    logic [N_REQ-1:0] rot;
    // rot[k] is req[(ptr+k) mod N_REQ]
    assign rot   = N_REQ'({req, req} >> ptr);
    assign valid = |req;
    always_comb begin
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) idx = IW'((int'(ptr) + k) % N_REQ);
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one fifo write port among N_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int F_WIDTH = 8,
    parameter int BURST   = 2
) (
    input logic clk,
    input logic rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IW = rr_idx_w(N_REQ);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d, ptr_q, ptr_d, pick_idx;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic              pick_valid, own, acc, last;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign own  = state_q == OWN;
    assign acc  = own & bus.req[owner_q] & ~bus.fifo_full;
    assign last = cnt_q == BEAT_W'(BURST - 1);

    assign bus.fifo_enq = acc;
    assign bus.gnt      = acc ? N_REQ'(1) << owner_q : '0;
    assign bus.fifo_din = acc ? bus.din_bus[int'(owner_q)*F_WIDTH +: F_WIDTH] : '0;
    assign bus.busy     = own;
    assign bus.owner    = owner_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // A dropped request releases immediately; a full fifo simply holds the grant.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!own) begin
            if (pick_valid) begin
                state_d = OWN;
                owner_d = pick_idx;
                cnt_d   = '0;
            end
        end else if (!bus.req[owner_q] || (acc && last)) begin
            state_d = IDLE;
            ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (acc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo` write port (`enq`/`din`/`full`) between `N_REQ` producers. It grants one producer at a time for a burst of up to `BURST` accepted beats, stalls on `full`, then rotates priority. It sits directly in front of the `fifo` instance. The consumer side (`deq`/`dout`/`empty`) is untouched.

## Interface
- `N_REQ`, 4: number of producers, 2..16.
- `F_WIDTH`, 8: data width, equal to the `fifo` `F_WIDTH`.
- `BURST`, 2: maximum accepted beats per grant, 1..255.
- `clk`  in  1: the single clock; all state is on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req`  in  N_REQ: per-producer request, level.
- `din_bus`  in  N_REQ*F_WIDTH: producer i data on bits [i*F_WIDTH +: F_WIDTH].
- `gnt`  out  N_REQ: one-hot; `gnt[i]`=1 means producer i's beat is written this cycle.
- `fifo_full`  in  1: from the `fifo` `full`.
- `fifo_enq`  out  1: to the `fifo` `enq`.
- `fifo_din`  out  F_WIDTH: to the `fifo` `din`.
- `busy`  out  1: 1 while a producer owns the port.
- `owner`  out  $clog2(N_REQ): current or last owner index.

## Operation
- States: IDLE, OWN. Registers: `state`, `owner`, `ptr` (round-robin start), `beat_cnt` (8 bit).
- IDLE:
  - If `req`==0, stay.
  - Otherwise the winner is the first i with `req[i]`=1, scanning `ptr`, `ptr+1`, … mod N_REQ.
  - Next cycle: `state`=OWN, `owner`=winner, `beat_cnt`=0.
  - No write occurs in IDLE.
- OWN, combinational outputs:
  - `acc` = `req[owner]` & !`fifo_full`.
  - `fifo_enq` = `acc`.
  - `gnt` = `acc` << `owner`.
  - `fifo_din` = owner's slice when `acc`, else 0.
- OWN, transitions:
  - `acc` & `beat_cnt`==BURST-1: release.
  - `acc` otherwise: `beat_cnt`++.
  - `req[owner]`=0: release that cycle with no write.
  - `fifo_full` & `req[owner]`: hold. `beat_cnt` is unchanged and all `gnt` are 0.
- Release: `state`=IDLE, `ptr`=(`owner`+1) mod N_REQ, `owner` holds its value.
- Producer rule: hold `req` and data stable until `gnt[i]` is seen. The beat is consumed at the edge where `gnt[i]`=1. Dropping `req` forfeits the grant.
- Requests from non-owners are ignored during OWN. They are not queued; they simply compete at the next IDLE.
- `busy` = (`state`==OWN).

## Timing
- Reset values: `state`=IDLE, `ptr`=0, `owner`=0, `beat_cnt`=0. Outputs `gnt`=0, `fifo_enq`=0, `fifo_din`=0, `busy`=0.
- Arbitration latency: the first write happens in the cycle after IDLE sees `req`. Per grant the cost is 1 IDLE cycle plus up to BURST write cycles.
- Throughput: BURST/(BURST+1) beats per cycle with continuous requests.
- Fairness: a held `req[i]` is granted within (N_REQ-1)*(BURST+1)+1 cycles, not counting cycles with `fifo_full`=1.
- `fifo_full` is sampled combinationally in the same cycle. The arbiter never asserts `fifo_enq` while `fifo_full`=1.
- A simultaneous `fifo` `deq` that clears `full` in a cycle takes effect next cycle; the arbiter only sees the updated `full`.
- `ptr` wrap: owner N_REQ-1 releases to `ptr`=0.
- Async `rst` mid-burst: all outputs drop immediately. The partial burst is abandoned, no beat is duplicated, and arbitration restarts from `ptr`=0.

## Structure
- Package `fifo_arb_pkg` holds:
  - enum `arb_state_t` {IDLE, OWN};
  - `BEAT_W`=8;
  - function `rr_idx_w(n)` = $clog2(n), minimum 1.
- Sub-module `rr_pick`: combinational rotate-priority picker. Inputs `req`, `ptr`; outputs `valid`, `idx`. It is reused by later read-side schedulers.
- Top contains only the FSM, the counters and the output muxing. Expected size is about 150–250 lines with `rr_pick`.

## Test plan
- Bench uses `fifo` F_DEPTH=4, F_WIDTH=8, plus this block with N_REQ=4 and BURST=2.
- Reset: assert `rst` mid-cycle → `gnt`=0, `fifo_enq`=0, `fifo_din`=0, `busy`=0 immediately. First grant after release goes to the lowest requesting index.
- Single producer: `req`=4'b0100 with data 8'h11, 8'h22, 8'h33 and no `deq`.
  - → IDLE 1 cycle, `gnt`=4'b0100 for 2 cycles (11, 22), then 1 idle cycle, then 33.
  - → `fifo` holds 11, 22, 33 in order.
- Round-robin: `req`=4'b1111 held, `deq`=1 every cycle.
  - → owner sequence 0,1,2,3,0.
  - → each owner gets exactly 2 beats.
  - → `fifo_enq` duty is 2 of every 3 cycles.
- Full stall: no `deq`, `req`=4'b0001 streaming 8'h01..8'h06.
  - → `fifo_enq` stops after 4 writes (`full`=1).
  - → `gnt` stays 0 and `busy` stays 1 while `full`.
  - → one `deq` resumes the stream with 8'h05 and no loss or duplicate.
- Drop request: owner 1 drops `req` after 1 beat while `req[2]`=1.
  - → release with no write in that cycle.
  - → next owner is 2.
  - → `fifo` contains exactly 1 beat from producer 1.
- Mid-burst reset: `rst` pulsed during owner 3's second beat.
  - → no write in that cycle, `ptr`=0.
  - → with `req`=4'b1000 the next grant goes to 3 after 1 IDLE cycle.
